// File: rtl/ctl_reg_pkg.sv
// ctl_reg_pkg: shared definitions for the controller register bank.
//   - Word addresses of the controller register map.
//   - Commit handshake FSM state type.
//   - Scratch window bounds, used when CTL_READBACK_EN is defined.
package ctl_reg_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_CTL_FLAG       = 14'h0000;
    localparam logic [ADDR_W-1:0] ADDR_FPGA_INFO      = 14'h0001;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT         = 14'h0002;
    localparam logic [ADDR_W-1:0] ADDR_MOD_CYCLE      = 14'h0003;
    localparam logic [ADDR_W-1:0] ADDR_MOD_FREQ_DIV_0 = 14'h0004;
    localparam logic [ADDR_W-1:0] ADDR_MOD_FREQ_DIV_1 = 14'h0005;
    localparam logic [ADDR_W-1:0] ADDR_SILENT_STEP    = 14'h0006;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH_FIRST  = 14'h0007;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH_LAST   = 14'h003E;
    localparam logic [ADDR_W-1:0] ADDR_VERSION        = 14'h003F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } ctl_state_t;

endpackage

// File: rtl/ctl_reg_bank_if.sv
// ctl_reg_bank_if: controller port of the CPU bus (BUS_CLK domain).
//   CTL_EN    : controller region selected
//   WE        : CPU write strobe (level; a write needs two consecutive high samples)
//   BRAM_ADDR : word address
//   DATA_IN   : CPU write data
//   DATA_OUT  : registered read data, one cycle after address/CTL_EN
// Handshake: there is no valid/ready pair on this port. A write is accepted when
// WE & CTL_EN has been sampled high on exactly two consecutive edges; a read is
// always accepted and answered on the next edge.
interface ctl_reg_bank_if;
    import ctl_reg_pkg::*;

    logic              CTL_EN;
    logic              WE;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic [DATA_W-1:0] DATA_IN;
    logic [DATA_W-1:0] DATA_OUT;

    modport master (
        output CTL_EN, WE, BRAM_ADDR, DATA_IN,
        input  DATA_OUT
    );

    modport slave (
        input  CTL_EN, WE, BRAM_ADDR, DATA_IN,
        output DATA_OUT
    );
endinterface

// File: rtl/we_edge_det.sv
// we_edge_det: write-strobe qualifier.
//   clk, rst_n : clock, asynchronous active-low reset
//   we_in      : WE & CTL_EN, sampled every edge
//   wr_stb     : one-cycle pulse while the sample history is 3'b011
// A strobe seen for one sample never fires; a long strobe fires once.
module we_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic we_in,
    output logic wr_stb
);
    logic [2:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 3'b000;
        end else begin
            hist_q <= {hist_q[1:0], we_in};
        end
    end

    assign wr_stb = (hist_q == 3'b011);
endmodule

// File: rtl/ctl_reg_bank.sv
// ctl_reg_bank: controller register bank with a commit handshake to the core.
//   BUS_CLK, RST_N : clock, asynchronous active-low reset
//   bus            : CPU controller port (slave side)
//   FPGA_INFO      : read-only status word from the core (0x01)
//   CTL_FLAG, MOD_CYCLE, MOD_FREQ_DIV, SILENT_STEP : committed outputs
//   UPDATE_REQ / UPDATE_ACK : commit request to / acknowledge from the core
//   STATE_DBG      : current commit FSM state
// Optional feature macro: CTL_READBACK_EN (staging and scratch words read back;
// scratch storage exists only when it is defined).
module ctl_reg_bank
    import ctl_reg_pkg::*;
#(
    parameter logic [15:0] VERSION_NUM = 16'h0000,
    parameter int          REG_DEPTH   = 64
) (
    input  logic             BUS_CLK,
    input  logic             RST_N,
    ctl_reg_bank_if.slave    bus,
    input  logic [15:0]      FPGA_INFO,
    output logic [15:0]      CTL_FLAG,
    output logic [15:0]      MOD_CYCLE,
    output logic [31:0]      MOD_FREQ_DIV,
    output logic [15:0]      SILENT_STEP,
    output logic             UPDATE_REQ,
    input  logic             UPDATE_ACK,
    output ctl_state_t       STATE_DBG
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(REG_DEPTH);

    logic        wr_stb, in_range, wr_ok, busy;
    logic        commit_q;
    logic        pending_q, pending_d, copy_en;
    ctl_state_t  state_q, state_d;
    logic [15:0] ctl_flag_s, mod_cycle_s, div_lo_s, div_hi_s, silent_s;
    logic [15:0] rd_data;

    we_edge_det u_we_edge_det (
        .clk    (BUS_CLK),
        .rst_n  (RST_N),
        .we_in  (bus.WE & bus.CTL_EN),
        .wr_stb (wr_stb)
    );

    assign in_range = (bus.BRAM_ADDR < DEPTH_A);
    assign wr_ok    = wr_stb & in_range;

    // Staging registers and the registered commit pulse (one cycle after the write).
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctl_flag_s  <= '0;
            mod_cycle_s <= '0;
            div_lo_s    <= '0;
            div_hi_s    <= '0;
            silent_s    <= '0;
            commit_q    <= 1'b0;
        end else begin
            commit_q <= wr_ok & (bus.BRAM_ADDR == ADDR_COMMIT) & bus.DATA_IN[0];
            if (wr_ok) begin
                case (bus.BRAM_ADDR)
                    ADDR_CTL_FLAG:       ctl_flag_s  <= bus.DATA_IN;
                    ADDR_MOD_CYCLE:      mod_cycle_s <= bus.DATA_IN;
                    ADDR_MOD_FREQ_DIV_0: div_lo_s    <= bus.DATA_IN;
                    ADDR_MOD_FREQ_DIV_1: div_hi_s    <= bus.DATA_IN;
                    ADDR_SILENT_STEP:    silent_s    <= bus.DATA_IN;
                    default: ;
                endcase
            end
        end
    end

`ifdef CTL_READBACK_EN
    logic [15:0] scratch_q [7:62];
    logic        scr_hit;
    assign scr_hit = (bus.BRAM_ADDR >= ADDR_SCRATCH_FIRST) &&
                     (bus.BRAM_ADDR <= ADDR_SCRATCH_LAST);

    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 7; i <= 62; i++) scratch_q[i] <= '0;
        end else if (wr_ok && scr_hit) begin
            scratch_q[bus.BRAM_ADDR[5:0]] <= bus.DATA_IN;
        end
    end
`endif

    // Commit FSM: state register.
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Commit FSM: next state. A commit outside IDLE is remembered in pending;
    // any number of them collapse into a single follow-up request.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        copy_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_q || pending_q) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                end
            end
            REQ: begin
                if (commit_q) pending_d = 1'b1;
                if (UPDATE_ACK) begin
                    copy_en = 1'b1;
                    state_d = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (commit_q) pending_d = 1'b1;
                if (!UPDATE_ACK) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign UPDATE_REQ = (state_q == REQ);
    assign STATE_DBG  = state_q;
    assign busy       = (state_q != IDLE) | pending_q;

    // Committed outputs: copied together so both divider halves change on one edge.
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            CTL_FLAG     <= '0;
            MOD_CYCLE    <= '0;
            MOD_FREQ_DIV <= '0;
            SILENT_STEP  <= '0;
        end else if (copy_en) begin
            CTL_FLAG     <= ctl_flag_s;
            MOD_CYCLE    <= mod_cycle_s;
            MOD_FREQ_DIV <= {div_hi_s, div_lo_s};
            SILENT_STEP  <= silent_s;
        end
    end

    // Read mux.
    always_comb begin
        rd_data = '0;
        if (in_range) begin
            case (bus.BRAM_ADDR)
                ADDR_FPGA_INFO: rd_data = FPGA_INFO;
                ADDR_COMMIT:    rd_data = {15'b0, busy};
                ADDR_VERSION:   rd_data = VERSION_NUM;
`ifdef CTL_READBACK_EN
                ADDR_CTL_FLAG:       rd_data = ctl_flag_s;
                ADDR_MOD_CYCLE:      rd_data = mod_cycle_s;
                ADDR_MOD_FREQ_DIV_0: rd_data = div_lo_s;
                ADDR_MOD_FREQ_DIV_1: rd_data = div_hi_s;
                ADDR_SILENT_STEP:    rd_data = silent_s;
                default: if (scr_hit) rd_data = scratch_q[bus.BRAM_ADDR[5:0]];
`else
                default: rd_data = '0;
`endif
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.DATA_OUT <= '0;
        end else begin
            bus.DATA_OUT <= bus.CTL_EN ? rd_data : '0;
        end
    end
endmodule
